lpm_ram_dp_be: RTL and testbench

- Single-clock, simple dual-port RAM. One write port, one read port.
- Generalises the existing LPM dual-port RAM: per-byte write enables, selectable read-during-write (RDW) behaviour, selectable output register, a read-data valid flag, an address-error flag, and an optional hardware clear of the whole array after reset.
- Used as the standard buffer RAM under FIFOs and packet stores in the LPM library.

---
 rtl/lpm_ram_dp_be.sv | 189 ++++++++++++++++++
 tb/tb_lpm_ram_dp_be.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lpm_ram_dp_be.sv
// Single-clock simple dual-port RAM with per-byte write enables, selectable
// read-during-write result, optional output register and post-reset clear.

module lpm_ram_dp_be_lane #(
    parameter int BW       = 8,
    parameter int AW       = 5,
    parameter int NW       = 32,
    parameter bit NEW_DATA = 1'b0
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [BW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [BW-1:0] rdata
);
    logic [BW-1:0] mem [NW];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    // we is only ever raised for in-range addresses, so the bypass is safe
    always_comb begin
        rdata = mem[raddr];
        if (NEW_DATA && we && (waddr == raddr)) rdata = wdata;
    end
endmodule

module lpm_ram_dp_be #(
    parameter int    lpm_width      = 32,
    parameter int    lpm_byte_width = 8,
    parameter int    lpm_widthad    = 5,
    parameter int    lpm_numwords   = 1 << lpm_widthad,
    parameter string lpm_outdata    = "UNREGISTERED",
    parameter string lpm_rdw_mode   = "OLD_DATA",
    parameter string lpm_init_clear = "ON"
) (
    input  logic                                 clock,
    input  logic                                 aclr_n,
    input  logic                                 clken,
    input  logic [lpm_width-1:0]                 data,
    input  logic [lpm_widthad-1:0]               wraddress,
    input  logic                                 wren,
    input  logic [lpm_width/lpm_byte_width-1:0]  byteena,
    input  logic [lpm_widthad-1:0]               rdaddress,
    input  logic                                 rden,
    output logic [lpm_width-1:0]                 q,
    output logic                                 q_valid,
    output logic                                 busy,
    output logic                                 addr_err
);
    localparam int NB       = lpm_width / lpm_byte_width;
    localparam int BW       = lpm_byte_width;
    localparam int AW       = lpm_widthad;
    localparam bit REG_OUT  = (lpm_outdata == "REGISTERED");
    localparam bit NEW_DATA = (lpm_rdw_mode == "NEW_DATA");
    localparam bit INIT_CLR = (lpm_init_clear == "ON");
    localparam logic [AW-1:0] LAST = AW'(lpm_numwords - 1);

    typedef enum logic [0:0] {ST_CLEAR, ST_READY} state_t;

    state_t               state, state_nxt;
    logic                 ready;
    logic [AW-1:0]        clr_cnt;
    logic                 wr_ok, rd_ok;
    logic                 wr_acc, rd_acc, wr_go, rd_in, err_nxt;
    logic [AW-1:0]        lane_addr;
    logic [NB-1:0]        lane_we;
    logic [NB-1:0][BW-1:0] lane_wdata, lane_rdata;
    logic [lpm_width-1:0] rd_word;
    logic [lpm_width-1:0] q_r;
    logic                 qv_r;

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n)    state <= INIT_CLR ? ST_CLEAR : ST_READY;
        else if (clken) state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_CLEAR && clr_cnt == LAST) state_nxt = ST_READY;
    end

    always_comb begin
        busy  = (state == ST_CLEAR);
        ready = (state == ST_READY);
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n)             clr_cnt <= '0;
        else if (clken && busy)  clr_cnt <= clr_cnt + 1'b1;
    end

    // A full-size array has no illegal addresses; otherwise compare one bit wider
    generate
        if (lpm_numwords >= (1 << lpm_widthad)) begin : g_full
            assign wr_ok = 1'b1;
            assign rd_ok = 1'b1;
        end else begin : g_part
            localparam logic [AW:0] LIMIT = (AW+1)'(lpm_numwords);
            assign wr_ok = ({1'b0, wraddress} < LIMIT);
            assign rd_ok = ({1'b0, rdaddress} < LIMIT);
        end
    endgenerate

    // if/else so an unknown address lands in the out-of-range branch
    always_comb begin
        wr_acc  = ready && clken && wren;
        rd_acc  = ready && clken && rden;
        wr_go   = 1'b0;
        rd_in   = 1'b0;
        err_nxt = 1'b0;
        if (wr_acc) begin
            if (wr_ok) wr_go = 1'b1;
            else       err_nxt = 1'b1;
        end
        if (rd_acc) begin
            if (rd_ok) rd_in = 1'b1;
            else       err_nxt = 1'b1;
        end
    end

    always_comb begin
        lane_addr  = busy ? clr_cnt : wraddress;
        lane_wdata = busy ? '0 : data;
        for (int k = 0; k < NB; k++)
            lane_we[k] = (busy && clken) || (wr_go && byteena[k]);
    end

    generate
        for (genvar k = 0; k < NB; k++) begin : g_lane
            lpm_ram_dp_be_lane #(
                .BW(BW), .AW(AW), .NW(lpm_numwords), .NEW_DATA(NEW_DATA)
            ) u_lane (
                .clock (clock),
                .we    (lane_we[k]),
                .waddr (lane_addr),
                .wdata (lane_wdata[k]),
                .raddr (rdaddress),
                .rdata (lane_rdata[k])
            );
        end
    endgenerate

    always_comb begin
        rd_word = '0;
        if (rd_in) rd_word = lane_rdata;
    end

    generate
        if (REG_OUT) begin : g_reg
            logic [lpm_width-1:0] s1_q;
            logic                 s1_v;
            always_ff @(posedge clock or negedge aclr_n) begin
                if (!aclr_n) begin
                    s1_q <= '0;
                    s1_v <= 1'b0;
                    q_r  <= '0;
                    qv_r <= 1'b0;
                end else if (clken) begin
                    s1_v <= rd_acc;
                    if (rd_acc) s1_q <= rd_word;
                    qv_r <= s1_v;
                    if (s1_v) q_r <= s1_q;
                end
            end
        end else begin : g_unreg
            always_ff @(posedge clock or negedge aclr_n) begin
                if (!aclr_n) begin
                    q_r  <= '0;
                    qv_r <= 1'b0;
                end else if (clken) begin
                    qv_r <= rd_acc;
                    if (rd_acc) q_r <= rd_word;
                end
            end
        end
    endgenerate

    // Error flag is a strict one-cycle pulse, so it is not held by clken
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) addr_err <= 1'b0;
        else         addr_err <= err_nxt;
    end

    assign q       = q_r;
    assign q_valid = qv_r;
endmodule

// File: tb/tb_lpm_ram_dp_be.sv
// Two instances share stimulus: 32 words/unregistered/OLD_DATA and
// 20 words/registered/NEW_DATA; a scoreboard checks data and read latency.

module tb_lpm_ram_dp_be;
    logic        clock = 1'b0;
    logic        aclr_n, clken, wren, rden;
    logic [31:0] data;
    logic [4:0]  wraddress, rdaddress;
    logic [3:0]  byteena;
    logic [31:0] q1, q2;
    logic        qv1, qv2, busy1, busy2, err1, err2;

    always #5 clock = ~clock;

    lpm_ram_dp_be u1 (
        .clock(clock), .aclr_n(aclr_n), .clken(clken), .data(data),
        .wraddress(wraddress), .wren(wren), .byteena(byteena),
        .rdaddress(rdaddress), .rden(rden), .q(q1), .q_valid(qv1),
        .busy(busy1), .addr_err(err1)
    );

    lpm_ram_dp_be #(
        .lpm_numwords(20), .lpm_outdata("REGISTERED"), .lpm_rdw_mode("NEW_DATA")
    ) u2 (
        .clock(clock), .aclr_n(aclr_n), .clken(clken), .data(data),
        .wraddress(wraddress), .wren(wren), .byteena(byteena),
        .rdaddress(rdaddress), .rden(rden), .q(q2), .q_valid(qv2),
        .busy(busy2), .addr_err(err2)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
    } sb_t;

    typedef struct {
        logic        w;
        logic [4:0]  wa;
        logic [31:0] d;
        logic [3:0]  be;
        logic        r;
        logic [4:0]  ra;
        logic [31:0] e1, e2;
        logic        er1, er2;
    } vec_t;

    int          checks = 0, failures = 0, ecnt = 0;
    sb_t         sb1[$], sb2[$];
    logic [31:0] last_q[2];
    logic        last_v[2];
    vec_t        tbl[26];
    int          n1, n2;

    function automatic vec_t v(logic w, logic [4:0] wa, logic [31:0] d, logic [3:0] be,
                               logic r, logic [4:0] ra, logic [31:0] e1, logic [31:0] e2,
                               logic er1, logic er2);
        vec_t t;
        t.w = w; t.wa = wa; t.d = d; t.be = be; t.r = r; t.ra = ra;
        t.e1 = e1; t.e2 = e2; t.er1 = er1; t.er2 = er2;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_port(input int id, input logic [31:0] qa, input logic va);
        sb_t e;
        bit  hit = 0;
        if (id == 0) begin
            while (sb1.size() > 0 && sb1[0].due < ecnt) begin
                e = sb1.pop_front();
                chk("lost_read0", 32'h0, e.data ^ 32'h1);
            end
            if (sb1.size() > 0 && sb1[0].due == ecnt) begin e = sb1.pop_front(); hit = 1; end
        end else begin
            while (sb2.size() > 0 && sb2[0].due < ecnt) begin
                e = sb2.pop_front();
                chk("lost_read1", 32'h0, e.data ^ 32'h1);
            end
            if (sb2.size() > 0 && sb2[0].due == ecnt) begin e = sb2.pop_front(); hit = 1; end
        end
        if (hit) begin
            chk($sformatf("q_valid%0d", id), va, 1);
            chk($sformatf("q%0d", id), qa, e.data);
            last_q[id] = e.data;
            last_v[id] = 1'b1;
        end else begin
            chk($sformatf("q_valid_idle%0d", id), va, 0);
            chk($sformatf("q_hold%0d", id), qa, last_q[id]);
            last_v[id] = 1'b0;
        end
    endtask

    task automatic step(input logic en, input vec_t t);
        clken = en; wren = t.w; wraddress = t.wa; data = t.d; byteena = t.be;
        rden = t.r; rdaddress = t.ra;
        if (en && t.r) begin
            sb1.push_back('{ecnt + 1, t.e1});
            sb2.push_back('{ecnt + 2, t.e2});
        end
        @(posedge clock);
        @(negedge clock);
        if (en) begin
            ecnt++;
            chk_port(0, q1, qv1);
            chk_port(1, q2, qv2);
            chk("addr_err0", err1, t.er1);
            chk("addr_err1", err2, t.er2);
        end else begin
            chk("stall_qv0", qv1, last_v[0]);
            chk("stall_q0", q1, last_q[0]);
            chk("stall_qv1", qv2, last_v[1]);
            chk("stall_q1", q2, last_q[1]);
        end
    endtask

    // Runs from the release negedge until both instances leave the clear state
    task automatic count_busy(input int stall_at, input int stall_len, output int c1, output int c2);
        c1 = 0; c2 = 0;
        for (int i = 0; i < 100 && (busy1 || busy2); i++) begin
            if (busy1) c1++;
            if (busy2) c2++;
            chk("busy_qv0", qv1, 0);
            chk("busy_qv1", qv2, 0);
            chk("busy_err", err1 | err2, 0);
            clken = !(i >= stall_at && i < stall_at + stall_len);
            wren = (i >= 3 && i < 16); rden = wren;
            wraddress = 5'd2; rdaddress = 5'd0; data = 32'hFFFF_FFFF; byteena = 4'hF;
            @(negedge clock);
        end
        clken = 1'b1; wren = 1'b0; rden = 1'b0;
    endtask

    task automatic flush_model();
        sb1.delete(); sb2.delete();
        last_q[0] = '0; last_q[1] = '0;
        last_v[0] = 1'b0; last_v[1] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        tbl[0]  = v(1'b1, 5'd3,  32'hAABBCCDD, 4'hF, 1'b0, 5'd0,  32'h0, 32'h0, 1'b0, 1'b0);
        tbl[1]  = v(1'b1, 5'd3,  32'h11223344, 4'h5, 1'b0, 5'd0,  32'h0, 32'h0, 1'b0, 1'b0);
        tbl[2]  = v(1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd3,  32'hAA22CC44, 32'hAA22CC44, 1'b0, 1'b0);
        tbl[3]  = v(1'b1, 5'd3,  32'h55667788, 4'hA, 1'b1, 5'd3,  32'hAA22CC44, 32'h55227744, 1'b0, 1'b0);
        tbl[4]  = v(1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd3,  32'h55227744, 32'h55227744, 1'b0, 1'b0);
        tbl[5]  = v(1'b1, 5'd5,  32'h1,        4'hF, 1'b0, 5'd0,  32'h0, 32'h0, 1'b0, 1'b0);
        tbl[6]  = v(1'b1, 5'd5,  32'h2,        4'hF, 1'b1, 5'd5,  32'h1, 32'h2, 1'b0, 1'b0);
        tbl[7]  = v(1'b1, 5'd0,  32'h0A0A0A0A, 4'hF, 1'b1, 5'd5,  32'h2, 32'h2, 1'b0, 1'b0);
        tbl[8]  = v(1'b1, 5'd1,  32'h1B1B1B1B, 4'hF, 1'b1, 5'd0,  32'h0A0A0A0A, 32'h0A0A0A0A, 1'b0, 1'b0);
        tbl[9]  = v(1'b1, 5'd2,  32'h2C2C2C2C, 4'hF, 1'b1, 5'd1,  32'h1B1B1B1B, 32'h1B1B1B1B, 1'b0, 1'b0);
        tbl[10] = v(1'b1, 5'd2,  32'hFFFFFFFF, 4'h0, 1'b1, 5'd2,  32'h2C2C2C2C, 32'h2C2C2C2C, 1'b0, 1'b0);
        tbl[11] = v(1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd0,  32'h0A0A0A0A, 32'h0A0A0A0A, 1'b0, 1'b0);
        tbl[12] = v(1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd1,  32'h1B1B1B1B, 32'h1B1B1B1B, 1'b0, 1'b0);
        tbl[13] = v(1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd2,  32'h2C2C2C2C, 32'h2C2C2C2C, 1'b0, 1'b0);
        tbl[14] = v(1'b0, 5'd0,  32'h0,        4'h0, 1'b0, 5'd0,  32'h0, 32'h0, 1'b0, 1'b0);
        tbl[15] = v(1'b1, 5'd25, 32'h12345678, 4'hF, 1'b1, 5'd25, 32'h0, 32'h0, 1'b0, 1'b1);
        tbl[16] = v(1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd25, 32'h12345678, 32'h0, 1'b0, 1'b1);
        tbl[17] = v(1'b1, 5'd21, 32'hDEADBEEF, 4'hF, 1'b1, 5'd20, 32'h0, 32'h0, 1'b0, 1'b1);
        tbl[18] = v(1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd21, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
        tbl[19] = v(1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd5,  32'h2, 32'h2, 1'b0, 1'b0);
        tbl[20] = v(1'b1, 5'd19, 32'h19191919, 4'hF, 1'b1, 5'd19, 32'h0, 32'h19191919, 1'b0, 1'b0);
        tbl[21] = v(1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd19, 32'h19191919, 32'h19191919, 1'b0, 1'b0);
        tbl[22] = v(1'b1, 5'd20, 32'h1,        4'hF, 1'b1, 5'd4,  32'h0, 32'h0, 1'b0, 1'b1);
        tbl[23] = v(1'b1, 5'd30, 32'h1,        4'hF, 1'b1, 5'd31, 32'h0, 32'h0, 1'b0, 1'b1);
        tbl[24] = v(1'b0, 5'd0,  32'h0,        4'h0, 1'b0, 5'd0,  32'h0, 32'h0, 1'b0, 1'b0);
        tbl[25] = v(1'b0, 5'd0,  32'h0,        4'h0, 1'b0, 5'd0,  32'h0, 32'h0, 1'b0, 1'b0);

        aclr_n = 1'b0; clken = 1'b1; wren = 1'b0; rden = 1'b0;
        data = '0; wraddress = '0; rdaddress = '0; byteena = '0;
        flush_model();
        repeat (3) @(negedge clock);
        chk("rst_q0", q1, 0);    chk("rst_qv0", qv1, 0);
        chk("rst_q1", q2, 0);    chk("rst_qv1", qv2, 0);
        chk("rst_err", err1 | err2, 0);
        chk("rst_busy0", busy1, 1);  chk("rst_busy1", busy2, 1);

        aclr_n = 1'b1;
        count_busy(1000, 0, n1, n2);
        chk("clear_cycles0", n1, 32);
        chk("clear_cycles1", n2, 20);

        for (int a = 0; a < 32; a++)
            step(1'b1, v(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'(a), 32'h0, 32'h0, 1'b0, (a >= 20)));

        for (int i = 0; i < 26; i++) step(1'b1, tbl[i]);

        // Back-to-back reads with a one-cycle clock-enable stall in the middle
        step(1'b1, v(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd0, 32'h0A0A0A0A, 32'h0A0A0A0A, 1'b0, 1'b0));
        step(1'b1, v(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd1, 32'h1B1B1B1B, 32'h1B1B1B1B, 1'b0, 1'b0));
        step(1'b0, v(1'b1, 5'd2, 32'h0, 4'hF, 1'b1, 5'd2, 32'h0, 32'h0, 1'b0, 1'b0));
        step(1'b1, v(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd2, 32'h2C2C2C2C, 32'h2C2C2C2C, 1'b0, 1'b0));
        step(1'b1, tbl[24]);
        step(1'b1, tbl[24]);

        // Reset between a read request and its registered result
        clken = 1'b1; wren = 1'b0; rden = 1'b1; rdaddress = 5'd3;
        @(posedge clock);
        #2 aclr_n = 1'b0;
        #1;
        chk("midrd_q0", q1, 0);  chk("midrd_qv0", qv1, 0);
        chk("midrd_q1", q2, 0);  chk("midrd_qv1", qv2, 0);
        chk("midrd_busy", busy1, 1);
        rden = 1'b0;
        @(negedge clock);
        aclr_n = 1'b1;
        flush_model();
        repeat (10) begin
            @(negedge clock);
            chk("late_qv1", qv2, 0);
        end

        // Reset at clear cycle 10, then a full clear with a 3-cycle enable stall
        aclr_n = 1'b0;
        #1 chk("midclr_busy", busy1, 1);
        @(negedge clock);
        aclr_n = 1'b1;
        count_busy(5, 3, n1, n2);
        chk("reclear_cycles0", n1, 35);
        chk("reclear_cycles1", n2, 23);

        step(1'b1, v(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd3, 32'h0, 32'h0, 1'b0, 1'b0));
        step(1'b1, v(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd2, 32'h0, 32'h0, 1'b0, 1'b0));
        step(1'b1, v(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd5, 32'h0, 32'h0, 1'b0, 1'b0));
        step(1'b1, tbl[24]);
        step(1'b1, tbl[24]);
        chk("sb_empty", sb1.size() + sb2.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
